// File: rtl/fp_mac_pkg.sv
// Shared types, status bit indices and FP32 <-> real helpers for the
// simulation-only FP32 MAC pipe. Status decoding (fp_status) is only used
// when FP_MAC_STATUS_EN is defined.
package fp_mac_pkg;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        fp32_t a;
        fp32_t b;
        fp32_t c;
        logic  acc;
    } mac_op_t;

    localparam int STAT_ZERO    = 0;
    localparam int STAT_INF     = 1;
    localparam int STAT_INVALID = 2;
    localparam int STAT_TINY    = 3;
    localparam int STAT_HUGE    = 4;

    localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;
    localparam fp32_t FP32_QNAN     = 32'h7FC0_0000;

    // 2^-149 as an IEEE double: the weight of one FP32 denormal LSB.
    localparam logic [63:0] FP64_2_M149 = {1'b0, 11'd874, 52'd0};

    // Widen an FP32 bit pattern to a real (exact for every finite input).
    function automatic real fp32_to_real(input fp32_t x);
        real r;
        if (x[30:23] == 8'hFF) begin
            r = $bitstoreal({x[31], 11'h7FF, x[22:0], 29'd0});
        end else if (x[30:23] == 8'h00) begin
            r = real'(int'(x[22:0])) * $bitstoreal(FP64_2_M149);
            if (x[31]) r = -r;
        end else begin
            r = $bitstoreal({x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0});
        end
        return r;
    endfunction

    // Round an IEEE double bit pattern to FP32, round-to-nearest-even,
    // with gradual underflow and overflow to infinity. Every NaN maps to FP32_QNAN.
    function automatic fp32_t fp64_to_fp32(input logic [63:0] d);
        logic        s;
        logic [10:0] e;
        logic [51:0] m;
        logic [63:0] sig;
        logic [63:0] kept;
        logic [63:0] rem_mask;
        logic        rb;
        logic        st;
        logic        inc;
        int          se;
        int          sh;
        fp32_t       r;
        s = d[63];
        e = d[62:52];
        m = d[51:0];
        r = {s, 31'd0};
        if (e == 11'h7FF) begin
            r = (m != 52'd0) ? FP32_QNAN : {s, 31'h7F80_0000};
        end else if (e != 11'd0) begin
            se = int'(e) - 896;
            if (se >= 255) begin
                r = {s, 31'h7F80_0000};
            end else if (se >= 1) begin
                rb  = m[28];
                st  = |m[27:0];
                inc = rb & (st | m[29]);
                r   = {s, 31'({se[7:0], m[51:29]}) + 31'(inc)};
            end else begin
                // Result lands in the FP32 denormal range (or flushes to zero).
                sh = 30 - se;
                if (sh <= 54) begin
                    sig      = {11'd0, 1'b1, m};
                    kept     = sig >> sh;
                    rb       = sig[sh-1];
                    rem_mask = (64'd1 << (sh - 1)) - 64'd1;
                    st       = |(sig & rem_mask);
                    inc      = rb & (st | kept[0]);
                    r        = {s, kept[30:0] + 31'(inc)};
                end
            end
        end
        return r;
    endfunction

    function automatic logic fp_is_inf(input fp32_t x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    // Status bits that depend on the result alone; STAT_HUGE needs the operands.
    function automatic logic [7:0] fp_status(input fp32_t z);
        logic [7:0] s;
        s               = 8'd0;
        s[STAT_ZERO]    = (z[30:0] == 31'd0);
        s[STAT_INF]     = fp_is_inf(z);
        s[STAT_INVALID] = (z[30:23] == 8'hFF) && (z[22:0] != 23'd0);
        s[STAT_TINY]    = (z[30:23] == 8'h00) && (z[22:0] != 23'd0);
        return s;
    endfunction

endpackage

// File: rtl/sim_fp_mac_pipe_lane.sv
// One MAC lane: combinational z = a*b + c, product and sum each rounded to
// FP32. Status decoding is elaborated only when FP_MAC_STATUS_EN is defined.
module sim_fp_mac_lane
    import fp_mac_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    output logic [31:0] o_z,
    output logic [7:0]  o_status
);

    fp32_t w_prod;
    fp32_t w_sum;

    // Product rounded to FP32 first, then the sum rounded again.
    always_comb begin
        w_prod = fp64_to_fp32($realtobits(fp32_to_real(i_a) * fp32_to_real(i_b)));
        w_sum  = fp64_to_fp32($realtobits(fp32_to_real(w_prod) + fp32_to_real(i_c)));
    end

    assign o_z = w_sum;

`ifdef FP_MAC_STATUS_EN
    // Decode result class; huge means an infinity created by overflow.
    always_comb begin
        o_status            = fp_status(w_sum);
        o_status[STAT_HUGE] = fp_is_inf(w_sum) && !fp_is_inf(i_a) &&
                              !fp_is_inf(i_b) && !fp_is_inf(i_c);
    end
`else
    assign o_status = 8'd0;
`endif

endmodule

// File: rtl/sim_fp_mac_pipe.sv
// Multi-lane pipelined FP32 MAC for array/PE simulations.
// LATENCY-1 carry stages move operands untouched; the arithmetic happens while
// loading the output stage. The stall is global: every stage advances only when
// the output register is empty or being emitted.
// Handshake: a beat transfers on valid && ready at a rising clk edge, on both
// the input and the output side; out_z/out_status never change while
// out_valid && !out_ready.
// Optional macro: FP_MAC_STATUS_EN enables the per-lane out_status decode.
module sim_fp_mac_pipe
    import fp_mac_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int LATENCY   = 3,
    parameter int sig_width = 23,
    parameter int exp_width = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_acc,
    input  logic [LANES*32-1:0] in_a,
    input  logic [LANES*32-1:0] in_b,
    input  logic [LANES*32-1:0] in_c,
    input  logic [2:0]         rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*32-1:0] out_z,
    output logic [LANES*8-1:0]  out_status
);

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $fatal(1, "sim_fp_mac_pipe: LATENCY must be 1..8");
    end
    if (sig_width != 23 || exp_width != 8) begin : g_bad_format
        $fatal(1, "sim_fp_mac_pipe: only sig_width=23, exp_width=8 supported");
    end

    localparam int NC = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic                w_advance;
    logic                r_stg_vld [NC];
    mac_op_t             r_stg_op  [NC][LANES];
    mac_op_t             w_in_op   [LANES];
    logic                w_last_vld;
    mac_op_t             w_last_op [LANES];
    logic [LANES*32-1:0] w_c_eff;
    logic [LANES*32-1:0] w_lane_z;
    logic [LANES*8-1:0]  w_lane_stat;
    logic [LANES*32-1:0] r_out_z;
    logic                r_out_vld;
    logic                w_unused_rnd;

    assign w_unused_rnd = ^rnd;

    assign w_advance = !r_out_vld || out_ready;
    assign in_ready  = w_advance && !rst;
    assign out_valid = r_out_vld;
    assign out_z     = r_out_z;

    // Gather each lane's operands plus the shared accumulate flag.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_in_op[l] = {in_a[l*32 +: 32], in_b[l*32 +: 32], in_c[l*32 +: 32], in_acc};
        end
    end

    if (LATENCY > 1) begin : g_carry
        // Carry stages: shift valid and operands together whenever the pipe advances.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < NC; s++) r_stg_vld[s] <= 1'b0;
            end else if (w_advance) begin
                r_stg_vld[0] <= in_valid;
                r_stg_op[0]  <= w_in_op;
                for (int s = 1; s < NC; s++) begin
                    r_stg_vld[s] <= r_stg_vld[s-1];
                    r_stg_op[s]  <= r_stg_op[s-1];
                end
            end
        end

        // The last carry stage feeds the output stage.
        always_comb begin
            w_last_vld = r_stg_vld[NC-1];
            w_last_op  = r_stg_op[NC-1];
        end
    end else begin : g_direct
        // Single-cycle pipe: the accepted beat goes straight to the output stage.
        always_comb begin
            w_last_vld = in_valid;
            w_last_op  = w_in_op;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        // Accumulate uses the lane's currently held result as the addend.
        assign w_c_eff[l*32 +: 32] = w_last_op[l].acc ? r_out_z[l*32 +: 32] : w_last_op[l].c;

        sim_fp_mac_lane u_lane (
            .i_a      (w_last_op[l].a),
            .i_b      (w_last_op[l].b),
            .i_c      (w_c_eff[l*32 +: 32]),
            .o_z      (w_lane_z[l*32 +: 32]),
            .o_status (w_lane_stat[l*8 +: 8])
        );
    end

    // Output stage: load a new result on advance; a bubble clears valid but keeps z.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_out_z   <= {LANES{FP32_POS_ZERO}};
        end else if (w_advance) begin
            r_out_vld <= w_last_vld;
            if (w_last_vld) r_out_z <= w_lane_z;
        end
    end

`ifdef FP_MAC_STATUS_EN
    logic [LANES*8-1:0] r_out_status;

    // Status registered alongside the result it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_status <= '0;
        end else if (w_advance && w_last_vld) begin
            r_out_status <= w_lane_stat;
        end
    end

    assign out_status = r_out_status;
`else
    logic w_unused_stat;
    assign w_unused_stat = ^w_lane_stat;
    assign out_status    = '0;
`endif

endmodule

// File: tb/tb_sim_fp_mac_pipe.sv
// Directed bench for sim_fp_mac_pipe (LANES=4, LATENCY=3).
module tb_sim_fp_mac_pipe;

    localparam int LANES   = 4;
    localparam int LATENCY = 3;
    localparam int W       = LANES * 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_acc;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [W-1:0]  in_c;
    logic [2:0]    rnd;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_z;
    logic [LANES*8-1:0] out_status;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // FP32 encodings of 0.0 .. 7.0
    logic [31:0] int_tab [8] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                                 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sim_fp_mac_pipe #(.LANES(LANES), .LATENCY(LATENCY), .sig_width(23), .exp_width(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_acc     (in_acc),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .rnd        (rnd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_status (out_status)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic acc);
        in_valid = 1'b1;
        in_a     = {LANES{a}};
        in_b     = {LANES{b}};
        in_c     = {LANES{c}};
        in_acc   = acc;
        rnd      = 3'($urandom_range(0, 7));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_acc   = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; rnd = 3'd0;
        in_a = '0; in_b = '0; in_c = '0;
        idle();
        step(); step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_z !== '0) begin n_fail++; $display("FAIL reset_out_z got %h want 0", out_z); end
        n_checks++;
        if (out_status !== '0) begin n_fail++; $display("FAIL reset_status got %h want 0", out_status); end
        rst = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        set_beat(32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got %b want 1", in_ready); end
        step();
        idle();
        for (int c = 1; c < LATENCY; c++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid cycle %0d got %b want 0", c, out_valid); end
            step();
        end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency got out_valid %b want 1", out_valid); end
        n_checks++;
        if (out_z !== {LANES{32'h40E0_0000}}) begin n_fail++; $display("FAIL single_z got %h want %h", out_z, {LANES{32'h40E0_0000}}); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got out_valid %b want 0", out_valid); end
        n_checks++;
        if (out_z !== {LANES{32'h40E0_0000}}) begin n_fail++; $display("FAIL single_keep_z got %h want %h", out_z, {LANES{32'h40E0_0000}}); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va;
        logic [W-1:0] exp;
        int k = 0;
        int first = -1;
        int last  = -1;
        out_ready = 1'b1;
        exp_q.delete();
        for (int cyc = 0; cyc < 8 + LATENCY + 4; cyc++) begin
            if (cyc < 8) begin
                for (int l = 0; l < LANES; l++) va[l*32 +: 32] = int_tab[(cyc + l) % 8];
                set_beat(32'h0, 32'h3F80_0000, 32'h0, 1'b0);
                in_a = va;
                exp_q.push_back(va);
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cycle %0d got %b want 1", cyc, in_ready); end
            end else begin
                idle();
            end
            step();
            if (out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra got %h want no beat", out_z);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_z !== exp) begin n_fail++; $display("FAIL stream_z beat %0d got %h want %h", k, out_z, exp); end
                end
                k++;
            end
        end
        n_checks++;
        if (k !== 8) begin n_fail++; $display("FAIL stream_count got %0d want 8", k); end
        n_checks++;
        if (last - first !== 7) begin n_fail++; $display("FAIL stream_gapless got span %0d want 7", last - first); end
    endtask

    task automatic test_accumulate();
        logic [31:0] exp_tab [4] = '{32'h3FC0_0000, 32'h4060_0000, 32'h40B0_0000, 32'h40F0_0000};
        int k = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 4 + LATENCY + 3; cyc++) begin
            if (cyc == 0)     set_beat(32'h3F80_0000, 32'h3F80_0000, 32'h3F00_0000, 1'b0);
            else if (cyc < 4) set_beat(32'h3F80_0000, 32'h4000_0000, 32'h42C8_0000, 1'b1);
            else              idle();
            step();
            if (out_valid) begin
                n_checks++;
                if (k >= 4) begin
                    n_fail++; $display("FAIL acc_extra got %h want no beat", out_z);
                end else if (out_z !== {LANES{exp_tab[k]}}) begin
                    n_fail++; $display("FAIL acc_z beat %0d got %h want %h", k, out_z, {LANES{exp_tab[k]}});
                end
                k++;
            end
        end
        n_checks++;
        if (k !== 4) begin n_fail++; $display("FAIL acc_count got %0d want 4", k); end
    endtask

    task automatic test_backpressure();
        logic [31:0] vals [3] = '{32'h4120_0000, 32'h4130_0000, 32'h4140_0000};
        logic [W-1:0] exp;
        int k = 0;
        out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            set_beat(vals[i], 32'h3F80_0000, 32'h0, 1'b0);
            exp_q.push_back({LANES{vals[i]}});
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready beat %0d got %b want 1", i, in_ready); end
            step();
        end
        idle();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready); end
            n_checks++;
            if (out_valid !== 1'b1 || out_z !== {LANES{vals[0]}}) begin
                n_fail++; $display("FAIL bp_hold cycle %0d got valid %b z %h want 1 %h", c, out_valid, out_z, {LANES{vals[0]}});
            end
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_duplicate got %h want no beat", out_z);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_z !== exp) begin n_fail++; $display("FAIL bp_order beat %0d got %h want %h", k, out_z, exp); end
                end
                k++;
            end
            step();
        end
        n_checks++;
        if (k !== 3) begin n_fail++; $display("FAIL bp_count got %0d want 3", k); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b1;
        set_beat(32'h40A0_0000, 32'h3F80_0000, 32'h0, 1'b0);
        step();
        set_beat(32'h40C0_0000, 32'h3F80_0000, 32'h0, 1'b0);
        step();
        idle();
        rst = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_z !== '0) begin
            n_fail++; $display("FAIL rstmid_clear got valid %b z %h want 0 0", out_valid, out_z);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost cycle %0d got %b want 0", c, out_valid); end
            step();
        end
        set_beat(32'h4000_0000, 32'h4000_0000, 32'h42C8_0000, 1'b1);
        step();
        idle();
        wait_valid(LATENCY + 4, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rstmid_timeout got no out_valid want out_valid");
        end else if (out_z !== {LANES{32'h4080_0000}}) begin
            n_fail++; $display("FAIL rstmid_acc_z got %h want %h", out_z, {LANES{32'h4080_0000}});
        end
        step();
    endtask

    task automatic test_status();
        bit ok;
        logic [31:0] z0;
        out_ready = 1'b1;
        // inf * 0 -> NaN
        set_beat(32'h7F80_0000, 32'h0, 32'h0, 1'b0);
        step();
        idle();
        wait_valid(LATENCY + 4, ok);
        z0 = out_z[31:0];
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL nan_timeout got no out_valid want out_valid");
        end else if (!(z0[30:23] == 8'hFF && z0[22:0] != 23'd0)) begin
            n_fail++; $display("FAIL nan_z got %h want NaN", z0);
        end
`ifdef FP_MAC_STATUS_EN
        n_checks++;
        if (out_status !== {LANES{8'h04}}) begin n_fail++; $display("FAIL nan_status got %h want %h", out_status, {LANES{8'h04}}); end
`else
        n_checks++;
        if (out_status !== '0) begin n_fail++; $display("FAIL nan_status got %h want 0", out_status); end
`endif
        step();
        // 1e30 * 1e30 overflows to +inf
        set_beat(32'h7149_F2CA, 32'h7149_F2CA, 32'h0, 1'b0);
        step();
        idle();
        wait_valid(LATENCY + 4, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL huge_timeout got no out_valid want out_valid");
        end else if (out_z !== {LANES{32'h7F80_0000}}) begin
            n_fail++; $display("FAIL huge_z got %h want %h", out_z, {LANES{32'h7F80_0000}});
        end
`ifdef FP_MAC_STATUS_EN
        n_checks++;
        if (out_status !== {LANES{8'h12}}) begin n_fail++; $display("FAIL huge_status got %h want %h", out_status, {LANES{8'h12}}); end
`else
        n_checks++;
        if (out_status !== '0) begin n_fail++; $display("FAIL huge_status got %h want 0", out_status); end
`endif
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_accumulate();
        test_backpressure();
        test_reset_mid();
        test_status();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
